y86_mem_responder: RTL

- Memory-side responder for the y86_seq CPU bus (bus_A, bus_in, bus_out, bus_RE, bus_WE).
- Byte-addressed little-endian RAM. Reads are zero-latency; writes are registered.
- Adds a byte loader port for program preload during reset, a memory-mapped console byte output, access counters and a sticky bus-error flag.
- Sits beside the CPU in the SoC/testbench top as its only memory.

---
 rtl/y86_bus_pkg.sv | 21 ++
 rtl/y86_byte_ram.sv | 49 ++++
 rtl/y86_mem_responder.sv | 101 ++++++++++
 3 files changed

// File: rtl/y86_bus_pkg.sv
// Shared definitions for agents on the y86 CPU memory bus.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package y86_bus_pkg;

    localparam int BUS_W = 32;

    // Default console MMIO address, write-only.
    localparam logic [BUS_W-1:0] CON_ADDR_DFLT = 32'hFFFF_FFF0;

    // Assemble a 32-bit word from four bytes, b0 being the lowest address.
    function automatic logic [BUS_W-1:0] le_word(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/y86_byte_ram.sv
// Byte RAM: one 4-byte combinational read, one 4-byte write, one 1-byte write.
// Latency: reads zero cycles; writes commit at the clock edge.
// Backpressure: none; the parent resolves port priority.
//
// Ports: clk; rd_addr -> rd_dat (wrapping little-endian word);
//        wr4_vld/wr4_addr/wr4_dat (wrapping word write);
//        wr1_vld/wr1_addr/wr1_dat (single byte write).
// Contents are not reset.
module y86_byte_ram
    import y86_bus_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BUS_W-1:0]  rd_dat,
    input  logic              wr4_vld,
    input  logic [ADDR_W-1:0] wr4_addr,
    input  logic [BUS_W-1:0]  wr4_dat,
    input  logic              wr1_vld,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [7:0]        wr1_dat
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] THREE = ADDR_W'(3);

    logic [7:0] mem [DEPTH];

    // ADDR_W-wide adds wrap naturally modulo the RAM size.
    assign rd_dat = le_word(mem[rd_addr],       mem[rd_addr + ONE],
                            mem[rd_addr + TWO], mem[rd_addr + THREE]);

    // Word write is applied last so it wins should both ports ever collide.
    always_ff @(posedge clk) begin
        if (wr1_vld) begin
            mem[wr1_addr] <= wr1_dat;
        end
        if (wr4_vld) begin
            mem[wr4_addr]         <= wr4_dat[7:0];
            mem[wr4_addr + ONE]   <= wr4_dat[15:8];
            mem[wr4_addr + TWO]   <= wr4_dat[23:16];
            mem[wr4_addr + THREE] <= wr4_dat[31:24];
        end
    end

endmodule

// File: rtl/y86_mem_responder.sv
// Memory-side responder for the y86_seq CPU: RAM, loader, console, counters, err.
// Latency: reads combinational in the same cycle; writes/console/counters one cycle.
// Backpressure: CPU never stalled; the loader is stalled (ld_ready=0) by a CPU write.
//
// Ports: clk, rst (sync, active-high); bus_A/bus_RE/bus_WE/bus_out in, bus_in out;
//        ld_valid/ld_addr/ld_data in, ld_ready out; con_valid/con_data out;
//        rd_cnt/wr_cnt saturating access counts; err sticky bus error.
module y86_mem_responder
    import y86_bus_pkg::*;
#(
    parameter int               ADDR_W   = 12,
    parameter logic [BUS_W-1:0] CON_ADDR = CON_ADDR_DFLT,
    parameter int               CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  bus_A,
    input  logic              bus_RE,
    input  logic              bus_WE,
    input  logic [BUS_W-1:0]  bus_out,
    output logic [BUS_W-1:0]  bus_in,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              con_valid,
    output logic [7:0]        con_data,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              err
);

    logic             in_range;
    logic             is_con;
    logic             cpu_rd;
    logic             cpu_wr;
    logic             ram_wr4;
    logic             ram_wr1;
    logic             err_set;
    logic [BUS_W-1:0] ram_rd_dat;

    assign in_range = (bus_A[BUS_W-1:ADDR_W] == '0);
    assign is_con   = (bus_A == CON_ADDR);

    // CPU strobes have no effect at all while rst is high.
    assign cpu_rd = bus_RE && !rst;
    assign cpu_wr = bus_WE && !rst;

    // Loader yields to the CPU, but owns the RAM during reset (preload window).
    assign ld_ready = rst || !bus_WE;
    assign ram_wr1  = ld_valid && ld_ready;
    assign ram_wr4  = cpu_wr && in_range;

    // Read sees pre-edge RAM contents, so a colliding write is not forwarded.
    assign bus_in = (cpu_rd && in_range) ? ram_rd_dat : '0;

    // Console is write-only, so reads there are errors too; RE+WE together is illegal.
    assign err_set = (cpu_rd && (!in_range || is_con))
                  || (cpu_wr && !in_range && !is_con)
                  || (cpu_rd && cpu_wr);

    y86_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .rd_addr  (bus_A[ADDR_W-1:0]),
        .rd_dat   (ram_rd_dat),
        .wr4_vld  (ram_wr4),
        .wr4_addr (bus_A[ADDR_W-1:0]),
        .wr4_dat  (bus_out),
        .wr1_vld  (ram_wr1),
        .wr1_addr (ld_addr),
        .wr1_dat  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            con_valid <= 1'b0;
            con_data  <= 8'h00;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            err       <= 1'b0;
        end else begin
            con_valid <= cpu_wr && is_con && !in_range;
            if (cpu_wr && is_con && !in_range) begin
                con_data <= bus_out[7:0];
            end
            // Counters saturate rather than wrap.
            if (cpu_rd && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (cpu_wr && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule
